// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory read channel plus the decoder-facing
// presentation/redirect signals. master = fetch unit, slave = memory/decoder side.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ill_instr;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid, halted,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target, ill_instr
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid, halted,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_target, ill_instr
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: requests one word, presents it to the
// decoder, and handles redirects (including ones that race an in-flight read).
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, HOLD, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        req_en_q;
  logic [31:0] tgt;

  assign tgt = bus.redirect_target & ~32'h3;

  // Requests start one edge after reset release, so a read in flight at reset is never mistaken for ours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC & ~32'h3;
      kill_q   <= 1'b0;
      pend_q   <= 32'h0;
      instr_q  <= NOP;
      ipc_q    <= 32'h0;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      pend_q   <= pend_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      req_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      REQ: begin
        if (!req_en_q) begin
          if (bus.redirect) pc_d = tgt;
        end else if (bus.imem_ack) begin
          // A killed or redirected read still has to complete before the address may change.
          if (kill_q || bus.redirect) begin
            pc_d   = bus.redirect ? tgt : pend_q;
            kill_d = 1'b0;
          end else begin
            instr_d = bus.imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = HOLD;
          end
        end else if (bus.redirect) begin
          kill_d = 1'b1;
          pend_d = tgt;
        end
      end
      HOLD: begin
        if (bus.instr_ready && bus.ill_instr) begin
          state_d = HALT;
        end else if (bus.redirect) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (bus.instr_ready) begin
          state_d = REQ;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = REQ;
    endcase
  end

  assign bus.imem_req    = (state_q == REQ) && req_en_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios, then randomized traffic
// checked against a transaction-level model of which addresses get presented.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();
  instruction_fetch_if wb ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(wb));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_target = 32'h0; bus.ill_instr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model state for the random phase
  logic [31:0] exp_next;
  bit          hm;
  logic        p_valid, p_req, p_ack, p_ready, p_redir, p_ill;
  logic [31:0] p_tgt, p_addr, p_instr, p_pc;
  int          npres, nhalt, halt_cyc;

  initial begin
    logic [31:0] h_instr, h_pc;
    logic [31:0] wpc [2];
    int wcnt;
    logic wpv;

    clr_inputs();
    wb.imem_ack = 1'b0; wb.imem_rdata = 32'h0; wb.instr_ready = 1'b0;
    wb.redirect = 1'b0; wb.redirect_target = 32'h0; wb.ill_instr = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    chk("rst_instr", bus.instruction, 32'h0000_0013);
    chk("rst_pc", bus.instr_pc, 32'h0);
    rst_n = 1'b1;

    // Basic fetch, ack two cycles after request
    tick();
    chk("f_req", {31'b0, bus.imem_req}, 32'd1);
    chk("f_addr", bus.imem_addr, 32'h0);
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0050_0093; bus.instr_ready = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("f_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("f_instr", bus.instruction, 32'h0050_0093);
    chk("f_ipc", bus.instr_pc, 32'h0);
    chk("f_req_hold", {31'b0, bus.imem_req}, 32'd0);
    tick();
    chk("f_valid_drop", {31'b0, bus.instr_valid}, 32'd0);
    chk("f_next_addr", bus.imem_addr, 32'h4);

    // Stall in HOLD for 5 cycles
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_2222; bus.instr_ready = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    chk("s_valid", {31'b0, bus.instr_valid}, 32'd1);
    h_instr = bus.instruction; h_pc = bus.instr_pc;
    chk("s_ipc", h_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s_valid_hold", {31'b0, bus.instr_valid}, 32'd1);
      chk("s_instr_hold", bus.instruction, h_instr);
      chk("s_pc_hold", bus.instr_pc, h_pc);
      chk("s_req_low", {31'b0, bus.imem_req}, 32'd0);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("s_next_addr", bus.imem_addr, 32'h8);

    // Redirect before ack: data discarded, refetch at aligned target
    bus.redirect = 1'b1; bus.redirect_target = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    chk("k_addr_held", bus.imem_addr, 32'h8);
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    chk("k_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("k_req", {31'b0, bus.imem_req}, 32'd1);
    chk("k_addr", bus.imem_addr, 32'h100);

    // Ready plus redirect in HOLD
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2222_3333;
    tick();
    bus.imem_ack = 1'b0;
    chk("r_ipc", bus.instr_pc, 32'h100);
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h40;
    tick();
    clr_inputs();
    chk("r_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("r_addr", bus.imem_addr, 32'h40);

    // Illegal instruction beats a same-cycle redirect
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b1; bus.ill_instr = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h200;
    tick();
    clr_inputs();
    for (int i = 0; i < 6; i++) begin
      chk("h_halted", {31'b0, bus.halted}, 32'd1);
      chk("h_req", {31'b0, bus.imem_req}, 32'd0);
      chk("h_valid", {31'b0, bus.instr_valid}, 32'd0);
      bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h300;
      bus.instr_ready = 1'b1;
      tick();
    end
    do_reset();

    // Randomized traffic
    exp_next = 32'h0; hm = 1'b0; npres = 0; nhalt = 0; halt_cyc = 0;
    p_valid = 0; p_req = 0; p_ack = 0; p_ready = 0; p_redir = 0; p_ill = 0;
    p_tgt = 0; p_addr = 0; p_instr = 0; p_pc = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (!hm) begin
        if (p_valid && p_ready && p_ill) hm = 1'b1;
        else if (p_redir) exp_next = p_tgt & ~32'h3;
      end
      if (hm) begin
        chk("m_halted", {31'b0, bus.halted}, 32'd1);
        chk("m_halt_req", {31'b0, bus.imem_req}, 32'd0);
        chk("m_halt_valid", {31'b0, bus.instr_valid}, 32'd0);
        halt_cyc++;
      end else begin
        chk("m_not_halted", {31'b0, bus.halted}, 32'd0);
        if (bus.instr_valid && !p_valid) begin
          chk("m_pres_pc", bus.instr_pc, exp_next);
          chk("m_pres_instr", bus.instruction, mem(bus.instr_pc));
          exp_next = bus.instr_pc + 32'd4;
          npres++;
        end
        if (p_valid && !p_ready && !p_redir) begin
          chk("m_stall_valid", {31'b0, bus.instr_valid}, 32'd1);
          chk("m_stall_instr", bus.instruction, p_instr);
          chk("m_stall_pc", bus.instr_pc, p_pc);
        end
        if (p_valid && (p_ready || p_redir)) begin
          chk("m_leave_valid", {31'b0, bus.instr_valid}, 32'd0);
          chk("m_leave_req", {31'b0, bus.imem_req}, 32'd1);
        end
        if (p_req && !p_ack) begin
          chk("m_req_held", {31'b0, bus.imem_req}, 32'd1);
          chk("m_addr_held", bus.imem_addr, p_addr);
        end
        if (bus.imem_req) chk("m_addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
      end

      if (hm && halt_cyc > 4) begin
        nhalt++;
        do_reset();
        exp_next = 32'h0; hm = 1'b0; halt_cyc = 0;
        p_valid = 0; p_req = 0; p_ack = 0; p_ready = 0; p_redir = 0; p_ill = 0;
        continue;
      end

      p_valid = bus.instr_valid; p_req = bus.imem_req; p_addr = bus.imem_addr;
      p_instr = bus.instruction; p_pc = bus.instr_pc;

      if (bus.imem_req) begin
        bus.imem_ack = ($urandom_range(1, 0) == 1);
        bus.imem_rdata = mem(bus.imem_addr);
      end else begin
        bus.imem_ack = ($urandom_range(7, 0) == 0);
        bus.imem_rdata = $urandom;
      end
      bus.instr_ready = ($urandom_range(1, 0) == 1);
      bus.ill_instr = ($urandom_range(39, 0) == 0);
      bus.redirect = ($urandom_range(15, 0) == 0);
      bus.redirect_target = $urandom;
      p_ack = bus.imem_ack; p_ready = bus.instr_ready; p_ill = bus.ill_instr;
      p_redir = bus.redirect; p_tgt = bus.redirect_target;
    end
    chk("m_enough_presented", {31'b0, (npres > 50)}, 32'd1);
    chk("m_saw_halt", {31'b0, (nhalt > 0)}, 32'd1);

    // Reset PC at top of address space: pc+4 wraps to zero
    do_reset();
    wcnt = 0; wpv = 1'b0; wpc[0] = 32'hX; wpc[1] = 32'hX;
    wb.instr_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (wb.instr_valid && !wpv && wcnt < 2) begin
        wpc[wcnt] = wb.instr_pc;
        wcnt++;
      end
      wpv = wb.instr_valid;
      wb.imem_ack = wb.imem_req;
      wb.imem_rdata = mem(wb.imem_addr);
    end
    chk("w_count", wcnt, 32'd2);
    chk("w_pc0", wpc[0], 32'hFFFF_FFFC);
    chk("w_pc1", wpc[1], 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_req  output  1  SHALL flag an outstanding instruction-memory read.
REQ-005 imem_addr  output  32  SHALL be the read address, word-aligned.
REQ-006 imem_ack  input  1  SHALL flag that imem_rdata is valid this cycle.
REQ-007 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-008 instruction  output  32  SHALL be the registered instruction word driving the decoder.
REQ-009 instr_pc  output  32  SHALL be the address of the presented instruction.
REQ-010 instr_valid  output  1  SHALL flag that instruction/instr_pc are valid.
REQ-011 instr_ready  input  1  SHALL flag that the downstream stage consumes the instruction this cycle.
REQ-012 redirect  input  1  SHALL be a one-cycle pulse requesting a fetch from redirect_target.
REQ-013 redirect_target  input  32  SHALL be the new fetch address; bits [1:0] are ignored and treated as 00.
REQ-014 ill_instr  input  1  SHALL flag that the consumed instruction was not recognised by the decoder.
REQ-015 halted  output  1  SHALL flag that fetch has stopped after an illegal instruction.

Function
REQ-016 FSM SHALL have states REQ, HOLD, HALT plus a kill flag and a pending-target register.
REQ-017 REQ: imem_req=1; imem_addr=pc, held stable until imem_ack.
REQ-018 REQ + imem_ack + no kill + no redirect: instruction<=imem_rdata, instr_pc<=pc, pc<=pc+4, go HOLD; instr_valid=1 the cycle after ack (one-cycle latency).
REQ-019 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 HOLD: imem_req=0; instr_valid=1; instruction and instr_pc held stable until consumed or flushed.
REQ-021 HOLD + instr_ready + !ill_instr + !redirect: go REQ at next pc; instr_valid=0 next cycle.
REQ-022 HOLD + instr_ready + ill_instr: go HALT; ill_instr overrides a same-cycle redirect.
REQ-023 HOLD + redirect (with or without instr_ready, ill_instr low): pc<=redirect_target, go REQ; held instruction discarded.
REQ-024 REQ + redirect + no ack: set kill, pending<=redirect_target; address unchanged until ack.
REQ-025 Further redirect while kill is set: overwrite pending; last target wins.
REQ-026 REQ + ack + (kill or redirect): discard imem_rdata; pc<=redirect_target if redirect present this cycle, else pending; clear kill; stay REQ, new request at new address next cycle.
REQ-027 imem_ack while imem_req=0 SHALL be ignored.
REQ-028 ill_instr and instr_ready SHALL be ignored while instr_valid=0.
REQ-029 HALT: imem_req=0, instr_valid=0, halted=1; exit only via reset.

Reset
REQ-030 On rst_n low, immediately: state REQ, pc=RESET_PC, kill=0, pending=0, instruction=32'h0000_0013 (NOP), instr_pc=0, instr_valid=0, halted=0, imem_req=0.
REQ-031 imem_req SHALL rise on the first rising clk edge after rst_n deasserts; a read in flight at reset is abandoned.

Verification
REQ-032 Reset, ack two cycles after req, rdata=32'h0050_0093, ready=1 -> imem_addr=0, then instruction=32'h0050_0093, instr_pc=0, valid one cycle, next imem_addr=4.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> instruction, instr_pc, instr_valid stable, imem_req=0.
REQ-034 Redirect to 32'h0000_0103 in REQ before ack, ack later -> rdata discarded, instr_valid stays 0, next imem_addr=32'h0000_0100.
REQ-035 instr_ready + redirect to 32'h40 in HOLD -> instr_valid=0 next cycle, imem_addr=32'h40.
REQ-036 instr_ready + ill_instr + redirect in HOLD -> halted=1, imem_req=0 permanently until rst_n pulse.
REQ-037 RESET_PC=32'hFFFF_FFFC, two fetches -> instr_pc 32'hFFFF_FFFC then 32'h0000_0000.
